// File: rtl/hog_axil_master_if.sv
// AXI4-Lite bus bundle between the command-driven initiator and the accelerator GP slave port.
interface hog_axil_master_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hog_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI write/read out, one response back,
// plus a saturating count of non-OKAY responses.
module hog_axil_master #(
  parameter int unsigned C_S_AXI_GP_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_GP_ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_S_AXI_GP_DATA_WIDTH-1:0] cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_write,
  output logic [C_S_AXI_GP_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic [15:0]                      err_count,
  hog_axil_master_if.master                m_axi
);
  localparam int unsigned AW = C_S_AXI_GP_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_GP_DATA_WIDTH;
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [15:0]   err_q;
  logic          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic          cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;
  logic          cmd_hs, aw_done, w_done, b_hs, ar_hs, r_hs, rsp_hs, resp_err;
  logic [1:0]    cap_resp;

  // A channel is done once its valid has dropped or is handshaking this cycle.
  assign cmd_hs   = cmd_valid && cmd_ready;
  assign aw_done  = !awvalid_q || m_axi.awready;
  assign w_done   = !wvalid_q || m_axi.wready;
  assign b_hs     = m_axi.bvalid && bready_q;
  assign ar_hs    = arvalid_q && m_axi.arready;
  assign r_hs     = m_axi.rvalid && rready_q;
  assign rsp_hs   = rsp_valid && rsp_ready;
  assign cap_resp = b_hs ? m_axi.bresp : m_axi.rresp;
  assign resp_err = (b_hs || r_hs) && (cap_resp != 2'b00);

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign err_count     = err_q;

  // State and handshake-control registers; async clear drops every valid/ready at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs) state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = RSP;
      RD_REQ:  if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = RSP;
      RSP:     if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from where the FSM is heading.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_REQ);
    rready_d    = (state_d == RD_DATA);
    rsp_valid_d = (state_d == RSP);
    if (state_q == IDLE && state_d == WR_REQ) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end else if (state_q == WR_REQ) begin
      awvalid_d = awvalid_q && !m_axi.awready;
      wvalid_d  = wvalid_q && !m_axi.wready;
    end
  end

  // Command latch, response capture and saturating error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      err_q     <= 16'h0000;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr & ADDR_MASK;
        wdata_q <= cmd_wdata;
      end
      if (b_hs) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi.bresp;
      end else if (r_hs) begin
        rsp_write <= 1'b0;
        rsp_rdata <= m_axi.rdata;
        rsp_resp  <= m_axi.rresp;
      end
      if (resp_err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end
endmodule
